// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - RV32I pipeline hazard control and hazard-tag pipeline
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_pipe_ctrl #(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [4:0]       mem_rd,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic [4:0]       wb_rd,
  output logic             wb_regwrite,
  output logic [1:0]       state,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } act_e;

  localparam int SW = $clog2(MAX_STALL + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STALL);
  localparam logic [SW-1:0] STREAK_SAT = SW'(MAX_STALL + 1);

  act_e          act_d, state_q;
  logic [4:0]    ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic          ex_regwrite_q, ex_regwrite_d, ex_memread_q, ex_memread_d;
  logic [4:0]    mem_rd_q, mem_rd_d;
  logic          mem_regwrite_q, mem_regwrite_d, mem_memread_q, mem_memread_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_regwrite_q, wb_regwrite_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;

  always_comb begin
    act_d = ST_RUN;
    if (mem_busy)       act_d = ST_FREEZE;
    else if (stall_req) act_d = ST_STALL;
    else if (flush_req) act_d = ST_FLUSH;
  end

  assign pc_en       = (act_d == ST_RUN) || (act_d == ST_FLUSH);
  assign ifid_en     = (act_d == ST_RUN);
  assign ifid_flush  = (act_d == ST_FLUSH);
  assign idex_bubble = (act_d == ST_STALL) || (act_d == ST_FLUSH);

  always_comb begin
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_memread_d  = mem_memread_q;
    wb_rd_d        = wb_rd_q;
    wb_regwrite_d  = wb_regwrite_q;
    streak_d       = streak_q;
    err_d          = err_q;
    if (act_d != ST_FREEZE) begin
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      mem_memread_d  = ex_memread_q;
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      ex_rs1_d       = 5'd0;
      ex_rs2_d       = 5'd0;
      ex_rd_d        = 5'd0;
      ex_regwrite_d  = 1'b0;
      ex_memread_d   = 1'b0;
      if (act_d == ST_RUN && id_valid) begin
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        // x0 is never a real destination, so it must not trigger forwarding
        ex_regwrite_d = id_regwrite && (id_rd != 5'd0);
        ex_memread_d  = id_memread;
      end
    end
    case (act_d)
      ST_STALL: begin
        if (streak_q >= STREAK_MAX) begin
          streak_d = STREAK_SAT;
          err_d    = 1'b1;
        end else begin
          streak_d = streak_q + SW'(1);
        end
      end
      ST_RUN, ST_FLUSH: streak_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_RUN;
      ex_rs1_q       <= 5'd0;
      ex_rs2_q       <= 5'd0;
      ex_rd_q        <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= 5'd0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      streak_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= act_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      streak_q       <= streak_d;
      err_q          <= err_d;
    end
  end

  assign state        = state_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_regwrite  = ex_regwrite_q;
  assign ex_memread   = ex_memread_q;
  assign mem_rd       = mem_rd_q;
  assign mem_regwrite = mem_regwrite_q;
  assign mem_memread  = mem_memread_q;
  assign wb_rd        = wb_rd_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign hazard_err   = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act_d == ST_STALL) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (act_d == ST_FLUSH) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb/tb_hazard_pipe_ctrl.sv - directed and randomized bench for hazard_pipe_ctrl
module tb_hazard_pipe_ctrl;
  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic             id_valid, id_regwrite, id_memread;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             stall_req, flush_req, mem_busy;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic [1:0]       state;
  logic             hazard_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_pipe_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall_req(stall_req), .flush_req(flush_req), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .state(state), .hazard_err(hazard_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference pipeline: one record per stage, shifted as a whole per edge
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } tag_t;

  tag_t             m_ex, m_mem, m_wb;
  int               m_state, m_streak;
  logic             m_err;
  logic [CNT_W-1:0] m_scnt, m_fcnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int action();
    if (mem_busy)  return 3;
    if (stall_req) return 1;
    if (flush_req) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_state = 0; m_streak = 0; m_err = 1'b0;
    m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic model_step();
    int a;
    tag_t nxt;
    a = action();
    m_state = a;
    if (a != 3) begin
      nxt = '0;
      if (a == 0 && id_valid) begin
        nxt.rs1 = id_rs1;
        nxt.rs2 = id_rs2;
        nxt.rd  = id_rd;
        nxt.rw  = id_regwrite && (id_rd != 0);
        nxt.mr  = id_memread;
      end
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = nxt;
    end
    if (a == 1) begin
      if (m_streak + 1 > MAX_STALL) m_err = 1'b1;
      m_streak = (m_streak + 1 > MAX_STALL + 1) ? MAX_STALL + 1 : m_streak + 1;
      m_scnt++;
    end else if (a != 3) begin
      m_streak = 0;
    end
    if (a == 2) m_fcnt++;
  endtask

  task automatic check_all(input string ctx);
    int a;
    a = action();
    chk({ctx, ":pc_en"},       32'(pc_en),       32'(a == 0 || a == 2));
    chk({ctx, ":ifid_en"},     32'(ifid_en),     32'(a == 0));
    chk({ctx, ":ifid_flush"},  32'(ifid_flush),  32'(a == 2));
    chk({ctx, ":idex_bubble"}, 32'(idex_bubble), 32'(a == 1 || a == 2));
    chk({ctx, ":ex_tags"},     32'({ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread}), 32'(m_ex));
    chk({ctx, ":mem_tags"},    32'({mem_rd, mem_regwrite, mem_memread}), 32'({m_mem.rd, m_mem.rw, m_mem.mr}));
    chk({ctx, ":wb_tags"},     32'({wb_rd, wb_regwrite}), 32'({m_wb.rd, m_wb.rw}));
    chk({ctx, ":state"},       32'(state),       32'(m_state));
    chk({ctx, ":hazard_err"},  32'(hazard_err),  32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    chk({ctx, ":stall_cnt"},   stall_cnt,        m_scnt);
    chk({ctx, ":flush_cnt"},   flush_cnt,        m_fcnt);
`else
    chk({ctx, ":stall_cnt"},   stall_cnt,        32'd0);
    chk({ctx, ":flush_cnt"},   flush_cnt,        32'd0);
`endif
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic st, input logic fl, input logic mb);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_regwrite = rw; id_memread = mr;
    stall_req = st; flush_req = fl; mem_busy = mb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Called mid-cycle; releases reset well before the next rising edge
  task automatic do_reset(input string ctx);
    rstn = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ":in_reset"});
    #2;
    rstn = 1'b1;
  endtask

  logic [4:0] sv_ex, sv_mem, sv_wb;

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    model_reset();
    check_all("por");
    #4;
    rstn = 1'b1;

    // Reset while running
    drive(1, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0, 0);
    tick(); tick();
    check_all("run_pre_rst");
    do_reset("rst_run");
    chk("rst:ex_rd", 32'(ex_rd), 32'd0);
    chk("rst:state", 32'(state), 32'd0);
    chk("rst:pc_en", 32'(pc_en), 32'd1);
    chk("rst:hazard_err", 32'(hazard_err), 32'd0);

    // rd=5 travels EX -> MEM -> WB
    drive(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 0, 0);
    tick();
    chk("run:ex_rd5", 32'(ex_rd), 32'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("run:mem_rd5", 32'(mem_rd), 32'd5);
    chk("run:mem_memread", 32'(mem_memread), 32'd1);
    tick();
    chk("run:wb_rd5", 32'(wb_rd), 32'd5);
    chk("run:wb_regwrite", 32'(wb_regwrite), 32'd1);
    check_all("run");

    // One-cycle load-use stall
    drive(1, 5'd3, 5'd4, 5'd7, 1, 0, 1, 0, 0);
    chk("stall:pc_en", 32'(pc_en), 32'd0);
    chk("stall:ifid_en", 32'(ifid_en), 32'd0);
    tick();
    chk("stall:ex_rd0", 32'(ex_rd), 32'd0);
    chk("stall:state", 32'(state), 32'd1);
    drive(1, 5'd3, 5'd4, 5'd7, 1, 0, 0, 0, 0);
    tick();
    chk("stall:ex_rd7", 32'(ex_rd), 32'd7);
    check_all("stall");

    // Branch flush with rd=3 already in EX
    drive(1, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 0);
    tick();
    drive(1, 5'd1, 5'd1, 5'd9, 1, 0, 0, 1, 0);
    chk("flush:ifid_flush", 32'(ifid_flush), 32'd1);
    tick();
    chk("flush:ex_rd0", 32'(ex_rd), 32'd0);
    chk("flush:mem_rd3", 32'(mem_rd), 32'd3);
    chk("flush:state2", 32'(state), 32'd2);
    check_all("flush");

    // Freeze overrides stall and flush for three cycles
    sv_ex = ex_rd; sv_mem = mem_rd; sv_wb = wb_rd;
    drive(1, 5'd2, 5'd2, 5'd12, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz:state3", 32'(state), 32'd3);
      chk("frz:pc_en", 32'(pc_en), 32'd0);
      chk("frz:hold", 32'({ex_rd, mem_rd, wb_rd}), 32'({sv_ex, sv_mem, sv_wb}));
      check_all("frz");
    end

    // Watchdog: five consecutive stalls with MAX_STALL=4
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("wdog:err", 32'(hazard_err), 32'(i == 5));
    end
    drive(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
    tick();
    chk("wdog:sticky", 32'(hazard_err), 32'd1);
    chk("x0:ex_regwrite", 32'(ex_regwrite), 32'd0);
    check_all("wdog");

    // Reset in the middle of a freeze
    drive(1, 5'd6, 5'd6, 5'd6, 1, 0, 0, 0, 1);
    tick();
    do_reset("rst_frz");

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 5) == 0));
      check_all("rnd_pre");
      if ($urandom_range(0, 60) == 0) begin
        do_reset("rnd_rst");
      end else begin
        tick();
        check_all("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
